// File: rtl/cpu_controller_pkg.sv
// Shared types and constants for the instruction controller.
// CPU_CTRL_ILLEGAL_TRAP_EN adds the HALT trap state.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_ALU       = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        ,
        S_HALT      = 3'd7
`endif
    } state_t;

    typedef enum logic [2:0] {
        INS_ILL,
        INS_MOVI,
        INS_MOVR,
        INS_ADD,
        INS_CMP,
        INS_AND,
        INS_MVN
    } instr_t;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
    } ir_fields_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] VSEL_MDATA = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b01;
    localparam logic [1:0] VSEL_PC    = 2'b10;
    localparam logic [1:0] VSEL_C     = 2'b11;

endpackage

// File: rtl/cpu_controller_if.sv
// Control bundle from the controller to the 16-bit datapath.
// master = controller, slave = datapath.
interface cpu_controller_if;

    logic [2:0]  writenum;
    logic [2:0]  readnum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    modport master (
        output writenum, readnum, write,
        output loada, loadb, loadc, loads,
        output asel, bsel, vsel, shift, ALUop,
        output sximm5, sximm8
    );

    modport slave (
        input writenum, readnum, write,
        input loada, loadb, loadc, loads,
        input asel, bsel, vsel, shift, ALUop,
        input sximm5, sximm8
    );

endinterface

// File: rtl/cpu_controller_instr_dec.sv
// Combinational instruction decoder: fields, sign extension, legality.
// No state; everything is a pure function of the IR.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output instr_t      kind,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    ir_fields_t f;

    assign f      = ir;
    assign op     = f.op;
    assign rn     = f.rn;
    assign rd     = f.rd;
    assign sh     = f.sh;
    assign rm     = f.rm;
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    always_comb begin
        kind = INS_ILL;
        unique case (1'b1)
            (f.opcode == OPC_MOV && f.op == OP_MOVI): kind = INS_MOVI;
            (f.opcode == OPC_MOV && f.op == OP_MOVR): kind = INS_MOVR;
            (f.opcode == OPC_ALU && f.op == OP_ADD):  kind = INS_ADD;
            (f.opcode == OPC_ALU && f.op == OP_CMP):  kind = INS_CMP;
            (f.opcode == OPC_ALU && f.op == OP_AND):  kind = INS_AND;
            (f.opcode == OPC_ALU && f.op == OP_MVN):  kind = INS_MVN;
            default:                                  kind = INS_ILL;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// IR, decoder and multi-cycle control FSM for the 16-bit datapath.
// CPU_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap into HALT until reset.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] in,
    input  logic        s,
    output logic        w,
    output logic        illegal,
    cpu_controller_if.master dp
);

    state_t      state;
    state_t      state_nx;
    logic [15:0] ir;

    instr_t      kind;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic [15:0] sx5;
    logic [15:0] sx8;

    instr_dec u_dec (
        .ir     (ir),
        .kind   (kind),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm5 (sx5),
        .sximm8 (sx8)
    );

    assign dp.sximm5 = sx5;
    assign dp.sximm8 = sx8;

    // IR only accepts new words while idle, so it can update with s.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (load && state == S_WAIT)
                ir <= in;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT:
                if (s) state_nx = S_DECODE;
            S_DECODE:
                case (kind)
                    INS_MOVI: state_nx = S_WRITE_IMM;
                    INS_MOVR,
                    INS_MVN:  state_nx = S_GET_B;
                    INS_ADD,
                    INS_CMP,
                    INS_AND:  state_nx = S_GET_A;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                    default:  state_nx = S_HALT;
`else
                    default:  state_nx = S_WAIT;
`endif
                endcase
            S_GET_A:     state_nx = S_GET_B;
            S_GET_B:     state_nx = S_ALU;
            S_ALU:
                state_nx = (kind == INS_CMP) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_nx = S_WAIT;
            S_WRITE_IMM: state_nx = S_WAIT;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            S_HALT:      state_nx = S_HALT;
`endif
            default:     state_nx = S_WAIT;
        endcase
    end

    always_comb begin
        w           = 1'b0;
        illegal     = 1'b0;
        dp.writenum = 3'd0;
        dp.readnum  = 3'd0;
        dp.write    = 1'b0;
        dp.loada    = 1'b0;
        dp.loadb    = 1'b0;
        dp.loadc    = 1'b0;
        dp.loads    = 1'b0;
        dp.asel     = 1'b0;
        dp.bsel     = 1'b0;
        dp.vsel     = VSEL_MDATA;
        dp.shift    = 2'b00;
        dp.ALUop    = 2'b00;
        case (state)
            S_WAIT:
                w = 1'b1;
            S_DECODE:
                illegal = (kind == INS_ILL);
            S_GET_A: begin
                dp.readnum = rn;
                dp.loada   = 1'b1;
            end
            S_GET_B: begin
                dp.readnum = rm;
                dp.loadb   = 1'b1;
            end
            S_ALU: begin
                dp.shift = sh;
                dp.ALUop = (kind == INS_MOVR) ? 2'b00 : op;
                dp.asel  = (kind == INS_MOVR) || (kind == INS_MVN);
                dp.loads = (kind == INS_CMP);
                dp.loadc = (kind != INS_CMP);
            end
            S_WRITE_REG: begin
                dp.writenum = rd;
                dp.vsel     = VSEL_C;
                dp.write    = 1'b1;
            end
            S_WRITE_IMM: begin
                dp.writenum = rn;
                dp.vsel     = VSEL_IMM8;
                dp.write    = 1'b1;
            end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            S_HALT:
                illegal = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction register, decoder and control FSM that sequences the existing 16-bit datapath for one instruction at a time. It latches an instruction and decodes its fields and sign-extended immediates. After a start pulse it steps through the register-read, ALU and write-back cycles, driving every datapath control input, and raises `w` when the machine is idle. It sits between the instruction source (switches, a testbench, or a later fetch unit) and the datapath.

## Interface
Parameters: none.
- `clk` input 1: single clock, all state updates on its rising edge.
- `reset` input 1: asynchronous reset, active-low.
- `load` input 1: latch `in` into the instruction register (IR).
- `in` input 16: instruction word.
- `s` input 1: start execution of the instruction held in IR.
- `w` output 1: idle/ready, 1 only in state WAIT.
- `illegal` output 1: unsupported opcode detected (behaviour per Configuration).
- `writenum`, `readnum` output 3 each: register indices to the register file.
- `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel` output 1 each: datapath controls.
- `vsel`, `shift`, `ALUop` output 2 each: datapath controls.
- `sximm5`, `sximm8` output 16 each: sign-extended `IR[4:0]` and `IR[7:0]`.

## Operation
- IR fields: opcode `[15:13]`, op `[12:11]`, Rn `[10:8]`, Rd `[7:5]`, sh `[4:3]`, Rm `[2:0]`.
- Supported instructions:
  - opcode 110: op 10 = MOV Rn,#imm8; op 00 = MOV Rd,Rm{,sh}.
  - opcode 101: op 00 = ADD, op 01 = CMP, op 10 = AND, op 11 = MVN.
  - Any other opcode/op pair is illegal.
- States: WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM, plus HALT (see Configuration).
- Transitions:
  - WAIT goes to DECODE when `s`=1; otherwise it holds.
  - From DECODE:
    - MOV imm goes to WRITE_IMM.
    - MOV reg and MVN go to GET_B.
    - ADD, CMP and AND go to GET_A.
    - Illegal goes to WAIT, or to HALT when the macro is enabled.
  - GET_A goes to GET_B, then GET_B goes to ALU.
  - ALU goes to WAIT for CMP and to WRITE_REG otherwise.
  - WRITE_REG and WRITE_IMM go to WAIT.
- Moore outputs. Every control is 0 unless listed for the state below:
  - WRITE_IMM: `writenum`=Rn, `vsel`=01, `write`=1.
  - GET_A: `readnum`=Rn, `loada`=1.
  - GET_B: `readnum`=Rm, `loadb`=1.
  - ALU: `shift`=sh, `bsel`=0, `ALUop`=op.
    - MOV reg: `ALUop`=00 and `asel`=1.
    - MVN: `asel`=1.
    - CMP: `loads`=1 and `loadc`=0; all others `loadc`=1.
  - WRITE_REG: `writenum`=Rd, `vsel`=11, `write`=1.
- `illegal` is 1 in the DECODE cycle of an illegal instruction. With the macro enabled it also stays 1 throughout HALT.
- `sximm5` and `sximm8` are combinational from IR and are valid in every state.

## Timing
- Reset values: state WAIT, IR=0, `w`=1, every other output 0 (`sximm5`/`sximm8` are 0 because IR=0).
- Reset is asynchronous. Asserting it mid-instruction returns the FSM to WAIT immediately and abandons the instruction; no further `write`, `loadc` or `loads` pulses occur.
- `load` is accepted only while `w`=1 and is ignored otherwise.
- `load` and `s` on the same edge in WAIT: execution uses the new `in` value, with IR and state updating together and decode occurring the following cycle.
- Latency, counted as rising edges from the `s` edge to `w` returning to 1:
  - MOV imm: 3.
  - MOV reg and MVN: 5.
  - ADD and AND: 6.
  - CMP: 5.
  - Illegal: 2.
- `s` held high in WAIT after completion starts the same instruction again. `s` is ignored in all other states.

## Configuration
- `CPU_CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode enters HALT.
  - In HALT, `w`=0, `illegal`=1 and all datapath controls are 0.
  - Only `reset` exits HALT.
- `CPU_CTRL_ILLEGAL_TRAP_EN` undefined: an illegal opcode behaves as a NOP that returns to WAIT, and the HALT state is not built.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum;
  - opcode/op constants (OPC_MOV=3'b110, OPC_ALU=3'b101);
  - `vsel` encodings (VSEL_MDATA=00, VSEL_IMM8=01, VSEL_PC=10, VSEL_C=11).
- Sub-module `instr_dec`: purely combinational field extraction, sign extension and legality check, instantiated once in `cpu_controller`.

## Test plan
- Load 0xD007 (MOV R0,#7), pulse `s`:
  - `sximm8`=0x0007;
  - `write`=1 with `writenum`=0 and `vsel`=01 exactly once;
  - `w`=1 three edges after `s`.
- Load 0xD1FF (MOV R1,#-1): `sximm8`=0xFFFF, and the write targets R1.
- Load 0xA049 (ADD R2,R0,R1 LSL#1):
  - GET_A `readnum`=0, then GET_B `readnum`=1;
  - ALU state with `shift`=01 and `loadc`=1;
  - WRITE_REG with `writenum`=2 and `vsel`=11;
  - six edges total.
- Load 0xA801 (CMP R0,R1):
  - `loads`=1 for one cycle and `loadc`=0;
  - no `write` pulse;
  - `w` returns after five edges.
- Load 0x0000 (illegal):
  - `illegal` pulses for one cycle;
  - macro off: `w`=1 after two edges;
  - macro on: `w` stays 0 until `reset`.
- Start ADD, then drop `reset` while in GET_B: `w`=1 immediately, all controls 0, and no `write` afterwards.
